// File: rtl/regfile_wb_pkg.sv
// Shared widths, source encodings and the writeback entry payload for the
// register-file writeback arbiter.
package regfile_wb_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_MEM = 1'b1;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
   } wb_entry;

endpackage

// File: rtl/wb_fifo.sv
// Small writeback-entry FIFO with registered full/empty flags and a
// combinational head view; push is ignored when full, pop when empty.
module wb_fifo
   import regfile_wb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    push,
   input  wb_entry push_entry,
   input  logic    pop,
   output logic    full,
   output logic    empty,
   output wb_entry head_c
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   wb_entry          mem_q [DEPTH];
   wb_entry          mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      do_push  = push && !full_q;
      do_pop   = pop && !empty_q;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_entry;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CNT_W'(DEPTH));
      empty_d = (count_d == CNT_W'(0));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   assign full   = full_q;
   assign empty  = empty_q;
   assign head_c = mem_q[rd_ptr_q];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writebacks with a
// starvation-bounded MEM-first arbiter. WB_BYPASS_EN adds read-port forwarding.
module regfile_wb_arbiter
   import regfile_wb_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [ADDR_W-1:0] alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic              RegWrite,
   output logic [ADDR_W-1:0] Write_register,
   output logic [DATA_W-1:0] Write_data,
   output logic              MemtoReg
`ifdef WB_BYPASS_EN
   ,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic              byp_hit1,
   output logic              byp_hit2,
   output logic [DATA_W-1:0] byp_data1,
   output logic [DATA_W-1:0] byp_data2
`endif
);

   localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

   wb_entry             alu_head, mem_head;
   wb_entry             alu_in, mem_in;
   logic                alu_full, alu_empty;
   logic                mem_full, mem_empty;
   logic                alu_push, mem_push;
   logic                grant_alu, grant_mem;

   logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
   logic                gnt_vld_q, gnt_vld_d;
   logic                gnt_src_q, gnt_src_d;
   wb_entry             gnt_entry_q, gnt_entry_d;
   logic                reg_write_q, reg_write_d;
   logic [ADDR_W-1:0]   write_register_q, write_register_d;
   logic [DATA_W-1:0]   write_data_q, write_data_d;
   logic                mem_to_reg_q, mem_to_reg_d;

   // Writes to x0 complete the handshake but are dropped before the FIFO.
   assign alu_ready = !alu_full;
   assign mem_ready = !mem_full;
   assign alu_push  = alu_valid && !alu_full && (alu_rd != ADDR_W'(0));
   assign mem_push  = mem_valid && !mem_full && (mem_rd != ADDR_W'(0));
   assign alu_in    = '{rd: alu_rd, data: alu_data};
   assign mem_in    = '{rd: mem_rd, data: mem_data};

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (alu_push),
      .push_entry (alu_in),
      .pop        (grant_alu),
      .full       (alu_full),
      .empty      (alu_empty),
      .head_c     (alu_head)
   );

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mem_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (mem_push),
      .push_entry (mem_in),
      .pop        (grant_mem),
      .full       (mem_full),
      .empty      (mem_empty),
      .head_c     (mem_head)
   );

   // MEM wins ties unless the ALU head has already waited STARVE_MAX grants.
   always_comb begin
      grant_alu    = !alu_empty &&
                     (mem_empty || (starve_cnt_q == STARVE_W'(STARVE_MAX)));
      grant_mem    = !mem_empty && !grant_alu;
      starve_cnt_d = starve_cnt_q;
      if (grant_alu || alu_empty) begin
         starve_cnt_d = '0;
      end else if (grant_mem && (starve_cnt_q != STARVE_W'(STARVE_MAX))) begin
         starve_cnt_d = starve_cnt_q + STARVE_W'(1);
      end
   end

   // Grant stage, then output register: two cycles from handshake to RegWrite.
   always_comb begin
      gnt_vld_d        = grant_alu || grant_mem;
      gnt_src_d        = gnt_src_q;
      gnt_entry_d      = gnt_entry_q;
      reg_write_d      = gnt_vld_q;
      write_register_d = write_register_q;
      write_data_d     = write_data_q;
      mem_to_reg_d     = mem_to_reg_q;
      if (grant_mem) begin
         gnt_src_d   = SRC_MEM;
         gnt_entry_d = mem_head;
      end else if (grant_alu) begin
         gnt_src_d   = SRC_ALU;
         gnt_entry_d = alu_head;
      end
      if (gnt_vld_q) begin
         write_register_d = gnt_entry_q.rd;
         write_data_d     = gnt_entry_q.data;
         mem_to_reg_d     = gnt_src_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt_q     <= '0;
         gnt_vld_q        <= 1'b0;
         gnt_src_q        <= SRC_ALU;
         gnt_entry_q      <= '0;
         reg_write_q      <= 1'b0;
         write_register_q <= '0;
         write_data_q     <= '0;
         mem_to_reg_q     <= 1'b0;
      end else begin
         starve_cnt_q     <= starve_cnt_d;
         gnt_vld_q        <= gnt_vld_d;
         gnt_src_q        <= gnt_src_d;
         gnt_entry_q      <= gnt_entry_d;
         reg_write_q      <= reg_write_d;
         write_register_q <= write_register_d;
         write_data_q     <= write_data_d;
         mem_to_reg_q     <= mem_to_reg_d;
      end
   end

   assign RegWrite       = reg_write_q;
   assign Write_register = write_register_q;
   assign Write_data     = write_data_q;
   assign MemtoReg       = mem_to_reg_q;

`ifdef WB_BYPASS_EN
   // Forward the write currently presented to the register file.
   always_comb begin
      byp_hit1  = RegWrite && (Write_register == rd_addr1) && (rd_addr1 != ADDR_W'(0));
      byp_hit2  = RegWrite && (Write_register == rd_addr2) && (rd_addr2 != ADDR_W'(0));
      byp_data1 = Write_data;
      byp_data2 = Write_data;
   end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed-vector bench for regfile_wb_arbiter: a per-cycle table plus
// sequences for starvation, full FIFO, reset flush and (optionally) bypass.
module tb_regfile_wb_arbiter;
   import regfile_wb_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              alu_valid, alu_ready, mem_valid, mem_ready;
   logic [ADDR_W-1:0] alu_rd, mem_rd, Write_register;
   logic [DATA_W-1:0] alu_data, mem_data, Write_data;
   logic              RegWrite, MemtoReg;
`ifdef WB_BYPASS_EN
   logic [ADDR_W-1:0] rd_addr1, rd_addr2;
   logic              byp_hit1, byp_hit2;
   logic [DATA_W-1:0] byp_data1, byp_data2;
`endif

   always #5 clk = ~clk;

   regfile_wb_arbiter dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .alu_valid      (alu_valid),
      .alu_ready      (alu_ready),
      .alu_rd         (alu_rd),
      .alu_data       (alu_data),
      .mem_valid      (mem_valid),
      .mem_ready      (mem_ready),
      .mem_rd         (mem_rd),
      .mem_data       (mem_data),
      .RegWrite       (RegWrite),
      .Write_register (Write_register),
      .Write_data     (Write_data),
      .MemtoReg       (MemtoReg)
`ifdef WB_BYPASS_EN
      ,
      .rd_addr1       (rd_addr1),
      .rd_addr2       (rd_addr2),
      .byp_hit1       (byp_hit1),
      .byp_hit2       (byp_hit2),
      .byp_data1      (byp_data1),
      .byp_data2      (byp_data2)
`endif
   );

   typedef struct {
      logic              av;
      logic [ADDR_W-1:0] ard;
      logic [DATA_W-1:0] adat;
      logic              mv;
      logic [ADDR_W-1:0] mrd;
      logic [DATA_W-1:0] mdat;
      logic              e_rw;
      logic [ADDR_W-1:0] e_wr;
      logic [DATA_W-1:0] e_wd;
      logic              e_src;
      logic              e_ardy;
      logic              e_mrdy;
   } vec_t;

   typedef struct packed {
      logic [ADDR_W-1:0] rd;
      logic [DATA_W-1:0] data;
      logic              src;
   } wr_t;

   localparam int NV = 21;
   vec_t vecs [NV];
   wr_t  wq [$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic hs_a, hs_m;
   int   k;

   function automatic vec_t mk(input logic av, input int ard, input int adat,
                               input logic mv, input int mrd, input int mdat,
                               input logic rw, input int wr, input int wd, input logic src);
      vec_t v;
      v.av = av;  v.ard = ADDR_W'(ard);  v.adat = DATA_W'(adat);
      v.mv = mv;  v.mrd = ADDR_W'(mrd);  v.mdat = DATA_W'(mdat);
      v.e_rw = rw; v.e_wr = ADDR_W'(wr); v.e_wd = DATA_W'(wd); v.e_src = src;
      v.e_ardy = 1'b1; v.e_mrdy = 1'b1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (RegWrite === 1'b1) wq.push_back({Write_register, Write_data, MemtoReg});
   endtask

   task automatic drive(input logic av, input int ard, input int adat,
                        input logic mv, input int mrd, input int mdat);
      alu_valid = av; alu_rd = ADDR_W'(ard); alu_data = DATA_W'(adat);
      mem_valid = mv; mem_rd = ADDR_W'(mrd); mem_data = DATA_W'(mdat);
   endtask

   task automatic chk_wr(input string name, input int idx, input int rd, input int data, input logic src);
      if (idx < wq.size()) begin
         chk({name, ".rd"},   64'(wq[idx].rd),   64'(rd));
         chk({name, ".data"}, 64'(wq[idx].data), 64'(data));
         chk({name, ".src"},  64'(wq[idx].src),  64'(src));
      end else begin
         chk({name, ".present"}, 64'(0), 64'(1));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(1, 3, 'hF,   0, 0, 0,     0, 0, 0, 0);
      vecs[1]  = mk(0, 0, 0,     0, 0, 0,     0, 0, 0, 0);
      vecs[2]  = mk(0, 0, 0,     0, 0, 0,     1, 3, 'hF, 0);
      vecs[3]  = mk(0, 0, 0,     0, 0, 0,     0, 3, 'hF, 0);
      vecs[4]  = mk(1, 5, 'hA,   1, 6, 'hB,   0, 3, 'hF, 0);
      vecs[5]  = mk(0, 0, 0,     0, 0, 0,     0, 3, 'hF, 0);
      vecs[6]  = mk(0, 0, 0,     0, 0, 0,     1, 6, 'hB, 1);
      vecs[7]  = mk(0, 0, 0,     0, 0, 0,     1, 5, 'hA, 0);
      vecs[8]  = mk(1, 0, 'h77,  0, 0, 0,     0, 5, 'hA, 0);
      vecs[9]  = mk(0, 0, 0,     1, 0, 'h99,  0, 5, 'hA, 0);
      vecs[10] = mk(0, 0, 0,     0, 0, 0,     0, 5, 'hA, 0);
      vecs[11] = mk(0, 0, 0,     0, 0, 0,     0, 5, 'hA, 0);
      vecs[12] = mk(1, 9, 'h1,   1, 9, 'h2,   0, 5, 'hA, 0);
      vecs[13] = mk(0, 0, 0,     0, 0, 0,     0, 5, 'hA, 0);
      vecs[14] = mk(0, 0, 0,     0, 0, 0,     1, 9, 'h2, 1);
      vecs[15] = mk(1, 10, 'h10, 0, 0, 0,     1, 9, 'h1, 0);
      vecs[16] = mk(1, 11, 'h11, 0, 0, 0,     0, 9, 'h1, 0);
      vecs[17] = mk(1, 12, 'h12, 0, 0, 0,     1, 10, 'h10, 0);
      vecs[18] = mk(0, 0, 0,     0, 0, 0,     1, 11, 'h11, 0);
      vecs[19] = mk(0, 0, 0,     0, 0, 0,     1, 12, 'h12, 0);
      vecs[20] = mk(0, 0, 0,     0, 0, 0,     0, 12, 'h12, 0);

      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
`ifdef WB_BYPASS_EN
      rd_addr1 = '0;
      rd_addr2 = '0;
`endif
      repeat (2) @(posedge clk);
      #1;
      chk("reset.rw",   64'(RegWrite), 64'(0));
      chk("reset.wr",   64'(Write_register), 64'(0));
      chk("reset.wd",   64'(Write_data), 64'(0));
      chk("reset.src",  64'(MemtoReg), 64'(0));
      chk("reset.ardy", 64'(alu_ready), 64'(1));
      chk("reset.mrdy", 64'(mem_ready), 64'(1));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table: inputs held for one cycle, outputs sampled just after that edge.
      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].av, int'(vecs[i].ard), int'(vecs[i].adat),
               vecs[i].mv, int'(vecs[i].mrd), int'(vecs[i].mdat));
         step();
         chk($sformatf("vec%0d.rw", i),   64'(RegWrite),       64'(vecs[i].e_rw));
         chk($sformatf("vec%0d.wr", i),   64'(Write_register), 64'(vecs[i].e_wr));
         chk($sformatf("vec%0d.wd", i),   64'(Write_data),     64'(vecs[i].e_wd));
         chk($sformatf("vec%0d.src", i),  64'(MemtoReg),       64'(vecs[i].e_src));
         chk($sformatf("vec%0d.ardy", i), 64'(alu_ready),      64'(vecs[i].e_ardy));
         chk($sformatf("vec%0d.mrdy", i), 64'(mem_ready),      64'(vecs[i].e_mrdy));
      end
      drive(0, 0, 0, 0, 0, 0);

      // Starvation: MEM streams continuously while one ALU entry waits.
      wq.delete();
      drive(1, 20, 'hA0, 1, 21, 'hB0);
      for (int c = 0; c < 16; c++) begin
         hs_a = alu_valid && alu_ready;
         hs_m = mem_valid && mem_ready;
         step();
         if (hs_a) alu_valid = 1'b0;
         if (hs_m) mem_data = mem_data + DATA_W'(1);
         if (c == 9) mem_valid = 1'b0;
      end
      chk_wr("starve.m0", 0, 21, 'hB0, 1);
      chk_wr("starve.m1", 1, 21, 'hB1, 1);
      chk_wr("starve.m2", 2, 21, 'hB2, 1);
      chk_wr("starve.m3", 3, 21, 'hB3, 1);
      chk_wr("starve.alu", 4, 20, 'hA0, 0);

      // Full ALU FIFO and an rd=0 request that must vanish.
      wq.delete();
      drive(1, 13, 'hC1, 1, 14, 'hD1);
      step();
      drive(1, 15, 'hC2, 1, 16, 'hD2);
      step();
      chk("full.ardy_low", 64'(alu_ready), 64'(0));
      drive(1, 0, 'hEE, 0, 0, 0);
      k = 0;
      hs_a = 1'b0;
      while (!hs_a && k < 10) begin
         hs_a = alu_valid && alu_ready;
         step();
         k++;
      end
      alu_valid = 1'b0;
      chk("full.rd0_accepted", 64'(hs_a), 64'(1));
      repeat (8) step();
      chk("full.nwrites", 64'(wq.size()), 64'(4));
      chk_wr("full.w0", 0, 14, 'hD1, 1);
      chk_wr("full.w1", 1, 16, 'hD2, 1);
      chk_wr("full.w2", 2, 13, 'hC1, 0);
      chk_wr("full.w3", 3, 15, 'hC2, 0);
      chk("full.ardy_back", 64'(alu_ready), 64'(1));

      // Reset mid-stream with work queued in both FIFOs.
      drive(1, 17, 'h171, 1, 18, 'h181);
      repeat (3) step();
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      #2;
      chk("rst_mid.rw_async", 64'(RegWrite), 64'(0));
      step();
      chk("rst_mid.rw",   64'(RegWrite), 64'(0));
      chk("rst_mid.ardy", 64'(alu_ready), 64'(1));
      chk("rst_mid.mrdy", 64'(mem_ready), 64'(1));
      chk("rst_mid.wr",   64'(Write_register), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      wq.delete();
      repeat (8) step();
      chk("rst_mid.no_stale", 64'(wq.size()), 64'(0));

`ifdef WB_BYPASS_EN
      wq.delete();
      rd_addr1 = ADDR_W'(7);
      rd_addr2 = ADDR_W'(0);
      drive(1, 7, 'h55, 0, 0, 0);
      step();
      alu_valid = 1'b0;
      k = 0;
      while (RegWrite !== 1'b1 && k < 6) begin
         step();
         k++;
      end
      chk("byp.rw",    64'(RegWrite), 64'(1));
      chk("byp.hit1",  64'(byp_hit1), 64'(1));
      chk("byp.data1", 64'(byp_data1), 64'(32'h55));
      chk("byp.hit2",  64'(byp_hit2), 64'(0));
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
